// File: rtl/mmio_hub_param_pkg.sv
// mmio_hub shared definitions: register offsets,
// timer control bit indices and hex glyph table.
package mmio_hub_pkg;

  localparam logic [7:0] OFF_LED      = 8'h00;
  localparam logic [7:0] OFF_SEGVAL   = 8'h04;
  localparam logic [7:0] OFF_SEGBLANK = 8'h08;
  localparam logic [7:0] OFF_SW       = 8'h0C;
  localparam logic [7:0] OFF_KEYLVL   = 8'h10;
  localparam logic [7:0] OFF_KEYPRESS = 8'h14;
  localparam logic [7:0] OFF_TCOUNT   = 8'h18;
  localparam logic [7:0] OFF_TRELOAD  = 8'h1C;
  localparam logic [7:0] OFF_TCTRL    = 8'h20;
  localparam logic [7:0] OFF_TSTAT    = 8'h24;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int STAT_EXP = 0;

  // active-low {g,f,e,d,c,b,a}, index 15 first
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/mmio_hub_param_if.sv
// CPU data-port / data-memory bus seen by the hub.
// master = CPU+memory side, slave = hub.
interface mmio_hub_param_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wmem;
  logic [31:0] mem_rdata;
  logic [31:0] cpu_rdata;
  logic        dmem_we;

  modport master (
    output addr, wdata, wmem, mem_rdata,
    input  cpu_rdata, dmem_we
  );

  modport slave (
    input  addr, wdata, wmem, mem_rdata,
    output cpu_rdata, dmem_we
  );

endinterface

// File: rtl/mmio_hub_param_hex7seg.sv
// One hex digit to active-low seven-segment glyph,
// forced dark when blanked.
module hex7seg
  import mmio_hub_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? 7'h7F : HEX_GLYPH[val];

endmodule

// File: rtl/mmio_hub_param.sv
// I/O window decode, LED/SEG/SW/KEY registers and
// prescaled down-counting timer in front of data memory.
module mmio_hub_param
  import mmio_hub_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00,
  parameter int LED_W    = 10,
  parameter int SW_W     = 10,
  parameter int KEY_W    = 4,
  parameter int N_SEG    = 6,
  parameter int PRESCALE = 50000
) (
  input  logic               clock,
  input  logic               resetn,
  mmio_hub_param_if.slave    bus,
  input  logic [SW_W-1:0]    sw,
  input  logic [KEY_W-1:0]   key,
  output logic [LED_W-1:0]   led,
  output logic [7*N_SEG-1:0] seg,
  output logic               timer_irq
);

  localparam logic [31:0] PS_MAX = 32'(PRESCALE - 1);

  logic       sel;
  logic [7:0] off;
  logic       wr;

  assign sel = bus.addr[31:8] == IO_BASE[31:8];
  assign off = bus.addr[7:0];
  assign wr  = bus.wmem & sel;

  logic is_led, is_segval, is_segblank, is_sw;
  logic is_keylvl, is_keypress, is_tcount;
  logic is_treload, is_tctrl, is_tstat;

  assign is_led      = off == OFF_LED;
  assign is_segval   = off == OFF_SEGVAL;
  assign is_segblank = off == OFF_SEGBLANK;
  assign is_sw       = off == OFF_SW;
  assign is_keylvl   = off == OFF_KEYLVL;
  assign is_keypress = off == OFF_KEYPRESS;
  assign is_tcount   = off == OFF_TCOUNT;
  assign is_treload  = off == OFF_TRELOAD;
  assign is_tctrl    = off == OFF_TCTRL;
  assign is_tstat    = off == OFF_TSTAT;

  logic [LED_W-1:0]   led_q;
  logic [4*N_SEG-1:0] seg_val;
  logic [N_SEG-1:0]   seg_blank;
  logic [SW_W-1:0]    sw_meta, sw_sync;
  logic [KEY_W-1:0]   key_meta, key_sync;
  logic [KEY_W-1:0]   key_prev, key_latch;
  logic [KEY_W-1:0]   key_rise, key_clr;
  logic [31:0]        tmr_count, tmr_reload;
  logic [31:0]        prescaler;
  logic [1:0]         ctrl;
  logic               expired;
  logic               tick, tmr_zero;

  assign key_rise = key_sync & ~key_prev;
  assign key_clr  = (wr & is_keypress) ?
                    bus.wdata[KEY_W-1:0] : '0;
  assign tick     = ctrl[CTRL_EN] && (prescaler == PS_MAX);
  assign tmr_zero = tmr_count == 32'd0;

  // CPU-writable display registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      led_q     <= '0;
      seg_val   <= '0;
      seg_blank <= '1;
    end else begin
      if (wr & is_led)
        led_q <= bus.wdata[LED_W-1:0];
      if (wr & is_segval)
        seg_val <= bus.wdata[4*N_SEG-1:0];
      if (wr & is_segblank)
        seg_blank <= bus.wdata[N_SEG-1:0];
    end
  end

  // input synchronisers and key press latch (set beats clear)
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      key_meta  <= '0;
      key_sync  <= '0;
      key_prev  <= '0;
      key_latch <= '0;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      key_meta  <= ~key;
      key_sync  <= key_meta;
      key_prev  <= key_sync;
      key_latch <= (key_latch & ~key_clr) | key_rise;
    end
  end

  // prescaled down-counter with one-shot / auto-reload
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tmr_count  <= '0;
      tmr_reload <= '0;
      prescaler  <= '0;
      ctrl       <= '0;
      expired    <= 1'b0;
    end else begin
      if (wr & is_tctrl)
        ctrl <= bus.wdata[1:0];
      else if (tick && tmr_zero && !ctrl[CTRL_AR])
        ctrl[CTRL_EN] <= 1'b0;

      if (!ctrl[CTRL_EN] || tick ||
          (wr && is_tctrl && bus.wdata[CTRL_EN]))
        prescaler <= '0;
      else
        prescaler <= prescaler + 32'd1;

      if (wr & is_treload)
        tmr_reload <= bus.wdata;

      if (wr && is_treload && !ctrl[CTRL_EN])
        tmr_count <= bus.wdata;
      else if (tick && !tmr_zero)
        tmr_count <= tmr_count - 32'd1;
      else if (tick && ctrl[CTRL_AR])
        tmr_count <= tmr_reload;

      expired <= (expired &
                  ~(wr & is_tstat & bus.wdata[STAT_EXP]))
               | (tick & tmr_zero);
    end
  end

  logic [31:0] io_rdata;

  // register read mux, zero-extended
  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      is_led:      io_rdata[LED_W-1:0]   = led_q;
      is_segval:   io_rdata[4*N_SEG-1:0] = seg_val;
      is_segblank: io_rdata[N_SEG-1:0]   = seg_blank;
      is_sw:       io_rdata[SW_W-1:0]    = sw_sync;
      is_keylvl:   io_rdata[KEY_W-1:0]   = key_sync;
      is_keypress: io_rdata[KEY_W-1:0]   = key_latch;
      is_tcount:   io_rdata              = tmr_count;
      is_treload:  io_rdata              = tmr_reload;
      is_tctrl:    io_rdata[1:0]         = ctrl;
      is_tstat:    io_rdata[STAT_EXP]    = expired;
      default:     io_rdata              = '0;
    endcase
  end

  assign bus.cpu_rdata = sel ? io_rdata : bus.mem_rdata;
  assign bus.dmem_we   = bus.wmem & ~sel;
  assign led           = led_q;
  assign timer_irq     = expired;

  for (genvar i = 0; i < N_SEG; i++) begin : g_dig
    hex7seg u_dig (
      .val   (seg_val[4*i +: 4]),
      .blank (seg_blank[i]),
      .seg   (seg[7*i +: 7])
    );
  end

  logic unused_ok;
  assign unused_ok = ^{bus.wdata, bus.addr[1:0]};

endmodule

// File: doc/mmio_hub_param.md
Name: mmio_hub_param

Overview:
- Parametrised memory-mapped I/O hub sitting between the single-cycle CPU data port and data memory.
- Decodes one I/O window; all other accesses pass through to data memory.
- Provides the following memory-mapped peripherals:
  - LED register.
  - N_SEG hex seven-segment digits with a per-digit blank mask.
  - Synchronised switches.
  - Synchronised keys with press-latch capture.
  - Prescaled down-counting timer with auto-reload and sticky expiry flag.
- Generalises the fixed LED/SEG/SW/KEY hub in the following ways:
  - Configurable widths and digit count.
  - Key edge capture.
  - Timer.

Parameters:
- IO_BASE, 32'hFFFF_FF00, base of 256-byte I/O window; sel = (addr[31:8] == IO_BASE[31:8]).
- LED_W, 10, LED register width (1..32).
- SW_W, 10, switch input width (1..32).
- KEY_W, 4, key input width (1..32).
- N_SEG, 6, seven-segment digit count (1..8).
- PRESCALE, 50000, clock cycles per timer tick (>=1).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  synchronous active-low reset, sampled on rising edge of clock.
- addr  in  32  CPU data address (byte address, word aligned).
- wdata  in  32  CPU store data.
- wmem  in  1  CPU store enable.
- mem_rdata  in  32  read data from data memory.
- cpu_rdata  out  32  read data returned to CPU.
- dmem_we  out  1  write enable to data memory = wmem & ~sel.
- sw  in  SW_W  raw switches.
- key  in  KEY_W  raw keys, active-low (pressed = 0).
- led  out  LED_W  LED drive.
- seg  out  7*N_SEG  digit i on seg[7i+6:7i], active-low segments {g..a}.
- timer_irq  out  1  level: timer expired flag.

Behaviour:
- Clock and reset:
  - Single clock `clock`.
  - Reset `resetn` is synchronous, active-low.
- Reset values:
  - led = 0; seg value = 0; blank mask all ones, so seg = all 7'h7F.
  - sw_sync = 0; key_sync = 0; key_latch = 0.
  - tmr_count = 0; tmr_reload = 0; ctrl = 0; expired = 0; prescaler = 0; timer_irq = 0.
- Register map (byte offset from IO_BASE, word accesses only):
  - 0x00 LED, RW, [LED_W-1:0].
  - 0x04 SEGVAL, RW, 4 bits per digit, digit 0 in [3:0].
  - 0x08 SEGBLANK, RW, [N_SEG-1:0]; 1 = digit dark.
  - 0x0C SW, RO.
  - 0x10 KEYLVL, RO, pressed = 1.
  - 0x14 KEYPRESS, RW1C.
  - 0x18 TCOUNT, RO.
  - 0x1C TRELOAD, RW.
  - 0x20 TCTRL, RW: bit0 enable, bit1 autoreload.
  - 0x24 TSTAT, RW1C: bit0 expired.
  - Unused offsets read 0; writes to them are ignored.
- Reads:
  - cpu_rdata is combinational: sel ? reg mux : mem_rdata.
  - Read data is zero-extended.
  - Zero added latency, matching single-cycle CPU timing.
- Writes:
  - Take effect on the rising edge with wmem & sel.
  - dmem_we is never asserted for I/O addresses.
- Input synchronisation:
  - sw and ~key each pass a 2-flop synchroniser.
  - Read values lag the pins by 2 cycles.
- Key press latch:
  - key_latch[i] sets on the cycle key_sync[i] rises from 0 to 1.
  - Cleared by writing 1 to that bit at 0x14.
  - A set and a clear in the same cycle: set wins.
- Timer:
  - The prescaler counts 0..PRESCALE-1 while enable = 1; tick = (prescaler == PRESCALE-1).
  - Prescaler holds at 0 while disabled.
  - On tick with tmr_count != 0: tmr_count decrements.
  - On tick with tmr_count == 0:
    - expired is set.
    - If autoreload = 1: tmr_count <= tmr_reload.
    - Else enable clears and tmr_count stays 0.
  - Writing TRELOAD also loads tmr_count when enable = 0; while enabled it only updates the reload value.
  - Writing TCTRL with enable = 1 restarts the prescaler at 0.
  - expired is cleared by writing bit0 = 1 at 0x24; hardware set wins over a same-cycle clear.
  - timer_irq = expired, registered.
  - tmr_count wrap is impossible: it never decrements below 0.
- Seven-segment:
  - Combinational hex decode of the registered value.
  - Blanked digit outputs 7'h7F.
  - Hex glyphs 0–F, active-low.
- Reset mid-operation: all state returns to reset values on the next edge; there is no partial completion.

Decomposition:
- Package mmio_hub_pkg holds:
  - Register offset localparams (OFF_LED..OFF_TSTAT).
  - TCTRL bit indices.
  - The 16-entry active-low hex glyph constant.
- One sub-module, hex7seg: 4-bit in, blank in, 7-bit out, combinational; instantiated N_SEG times via generate.

Test Plan:
- Reset:
  - Stimulus: resetn = 0 for 2 cycles.
  - Required: led = 0, every seg digit = 7'h7F, cpu_rdata at 0x18 = 0, timer_irq = 0.
- Write/read with pass-through:
  - Stimulus: store 0x3FF to IO_BASE+0x00, then 0x00000321 to +0x04, then 0x38 to +0x08.
  - Required:
    - led = 10'h3FF.
    - digit0 = 7'b1111001.
    - digit1 = 7'b0100100.
    - digit2 = 7'b0110000.
    - digits 3–5 = 7'h7F.
    - dmem_we = 0 during all three stores.
  - Then a store to 0x00000010: dmem_we = 1 and cpu_rdata = mem_rdata.
- Key capture:
  - Stimulus: key[2] driven 1→0.
  - Required:
    - Read 0x10 = 4'b0100 after 2 cycles.
    - 0x14 = 4'b0100 and holds after release.
  - Stimulus: write 0x4 to 0x14 on the same cycle as a new edge on key[2].
  - Required: bit remains 1.
- One-shot timer:
  - Stimulus: PRESCALE = 4, TRELOAD = 2, TCTRL = 1.
  - Required:
    - expired/timer_irq asserts after 3 ticks (12 cycles).
    - TCTRL reads 0.
    - TCOUNT stays 0.
  - Stimulus: write 1 to 0x24.
  - Required: timer_irq = 0.
- Auto-reload timer:
  - Stimulus: TRELOAD = 1, TCTRL = 3, PRESCALE = 4.
  - Required: expired set every 8 cycles; TCOUNT sequence 1, 0, 1, 0.
- Mid-run reset:
  - Stimulus: assert resetn = 0 mid-count.
  - Required: TCOUNT = 0, TCTRL = 0, key_latch = 0 on the next edge.
